// File: rtl/dac_config_sequencer.sv
// Serialises one parallel register write into the gpio_ctrl bit-serial protocol:
// sdata plus a per-register strobe, LSB first, framed by select_out.
module dac_config_sequencer #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned GPIO_WIDTH   = 16,
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned MUX_PULSES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_target,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic [GPIO_WIDTH-1:0] gpio_ctrl,
  output logic                  select_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned PhaseW = $clog2(PHASE_CYCLES + 1);
  localparam int unsigned IdxW   = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] TgtMux     = 3'd0;
  localparam logic [2:0] TgtCycle   = 3'd1;
  localparam logic [2:0] TgtMask    = 3'd2;
  localparam logic [2:0] TgtLock    = 3'd3;
  localparam logic [2:0] TgtPreDly  = 3'd4;
  localparam logic [2:0] TgtPostDly = 3'd5;

  // gpio_ctrl bit positions expected by the dac_driver gpio decoder
  localparam int unsigned SdataBit    = 0;
  localparam int unsigned MuxClkBit   = 1;
  localparam int unsigned CycleClkBit = 2;
  localparam int unsigned MaskClkBit  = 3;
  localparam int unsigned LockClkBit  = 4;
  localparam int unsigned PreClkBit   = 5;
  localparam int unsigned PostClkBit  = 6;

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            target_q, target_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
  logic [PhaseW-1:0]     phase_cnt_q, phase_cnt_d;

  logic            phase_end;
  logic [IdxW-1:0] last_idx;

  assign phase_end = (phase_cnt_q == PhaseW'(PHASE_CYCLES - 1));
  assign last_idx  = (target_q == TgtMux) ? IdxW'(MUX_PULSES - 1) : IdxW'(DATA_WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      target_q    <= '0;
      data_q      <= '0;
      bit_idx_q   <= '0;
      phase_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      data_q      <= data_d;
      bit_idx_q   <= bit_idx_d;
      phase_cnt_q <= phase_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    data_d      = data_q;
    bit_idx_d   = bit_idx_q;
    phase_cnt_d = phase_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          target_d    = cfg_target;
          data_d      = cfg_data;
          bit_idx_d   = '0;
          phase_cnt_d = '0;
          state_d     = (cfg_target > TgtPostDly) ? StDone : StSetup;
        end
      end
      StSetup: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          state_d     = StHigh;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          state_d     = StLow;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      StLow: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          if (bit_idx_q == last_idx) begin
            state_d = StDone;
          end else begin
            state_d   = StSetup;
            bit_idx_d = bit_idx_q + 1'b1;
            // MUX repeats bit 0 on every pulse, so its data never shifts
            if (target_q != TgtMux) data_d = data_q >> 1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gpio_ctrl  = '0;
    select_out = 1'b0;
    cfg_ready  = (state_q == StIdle) && !rst;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    err        = (state_q == StDone) && (target_q > TgtPostDly);
    if (state_q == StSetup || state_q == StHigh || state_q == StLow) begin
      select_out          = 1'b1;
      gpio_ctrl[SdataBit] = data_q[0];
    end
    if (state_q == StHigh) begin
      case (target_q)
        TgtMux:     gpio_ctrl[MuxClkBit]   = 1'b1;
        TgtCycle:   gpio_ctrl[CycleClkBit] = 1'b1;
        TgtMask:    gpio_ctrl[MaskClkBit]  = 1'b1;
        TgtLock:    gpio_ctrl[LockClkBit]  = 1'b1;
        TgtPreDly:  gpio_ctrl[PreClkBit]   = 1'b1;
        TgtPostDly: gpio_ctrl[PostClkBit]  = 1'b1;
        default:    ;
      endcase
    end
  end

endmodule
